// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter: FSM states, requester ids
// and the round-robin successor function.
package sram_arb_pkg;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_BLK = 2'd0,
        REQ_KEY = 2'd1,
        REQ_WR  = 2'd2
    } req_id_t;

    // Next requester id in the cyclic order 0,1,2,0,...
    function automatic logic [1:0] rr_next(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request found scanning
// cyclically from the pointer position.
module rr_picker
    import sram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_ptr,
    output req_id_t            o_grant,
    output logic               o_valid
);

    // Padded so the 2-bit scan index can never select past the vector.
    logic [3:0] w_req_ext;
    logic [1:0] w_idx;

    assign w_req_ext = {1'b0, i_req};

    always_comb begin
        o_valid = 1'b0;
        o_grant = REQ_BLK;
        w_idx   = i_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_valid && w_req_ext[w_idx]) begin
                o_valid = 1'b1;
                o_grant = req_id_t'(w_idx);
            end
            w_idx = rr_next(w_idx);
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Serializes block-read, key-read and write-back accesses onto one SRAM port,
// holding the enables for a fixed access time and owning the tri-state bus.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 128,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rd0_req,
    input  logic [ADDR_BITS-1:0] rd0_addr,
    output logic                 rd0_done,
    input  logic                 rd1_req,
    input  logic [ADDR_BITS-1:0] rd1_addr,
    output logic                 rd1_done,
    input  logic                 wr_req,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_done,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 busy,
    output logic                 sram_r_en,
    output logic                 sram_w_en,
    output logic [ADDR_BITS-1:0] sram_addr,
    inout  wire  [DATA_BITS-1:0] sram_data
);

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t                r_state, w_state_next;
    logic [3:0]            r_cnt, w_cnt_next;
    logic [1:0]            r_ptr;
    req_id_t               r_id;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [DATA_BITS-1:0]  r_wdata;
    logic [DATA_BITS-1:0]  r_rdata;
    req_id_t               w_grant;
    logic                  w_valid;
    logic                  w_last;

    rr_picker u_picker (
        .i_req   ({wr_req, rd1_req, rd0_req}),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    assign w_last = (r_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        sram_r_en    = 1'b0;
        sram_w_en    = 1'b0;
        sram_addr    = '0;
        rd0_done     = 1'b0;
        rd1_done     = 1'b0;
        wr_done      = 1'b0;
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_next = (w_grant == REQ_WR) ? WRITE : READ;
                    w_cnt_next   = 4'd0;
                end
            end
            READ, WRITE: begin
                sram_r_en = (r_state == READ);
                sram_w_en = (r_state == WRITE);
                sram_addr = r_addr;
                if (w_last) begin
                    w_state_next = DONE;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            DONE: begin
                rd0_done     = (r_id == REQ_BLK);
                rd1_done     = (r_id == REQ_KEY);
                wr_done      = (r_id == REQ_WR);
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Grant-time latches decouple the access in flight from later input changes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ptr   <= 2'd0;
            r_id    <= REQ_BLK;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == IDLE && w_valid) begin
                r_id <= w_grant;
                case (w_grant)
                    REQ_BLK: r_addr <= rd0_addr;
                    REQ_KEY: r_addr <= rd1_addr;
                    default: begin
                        r_addr  <= wr_addr;
                        r_wdata <= wr_data;
                    end
                endcase
            end
            if (r_state == READ && w_last) begin
                r_rdata <= sram_data;
            end
            if (r_state == DONE) begin
                r_ptr <= rr_next(r_id);
            end
        end
    end

    assign rdata     = r_rdata;
    assign sram_data = (r_state == WRITE) ? r_wdata : {DATA_BITS{1'bz}};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM on the shared bus.
module tb_sram_port_arbiter;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         rd0_req, rd1_req, wr_req;
    logic [7:0]   rd0_addr, rd1_addr, wr_addr;
    logic [127:0] wr_data;
    logic         rd0_done, rd1_done, wr_done, busy, sram_r_en, sram_w_en;
    logic [127:0] rdata;
    logic [7:0]   sram_addr;
    wire  [127:0] sram_data;
    logic [127:0] mem [0:255];

    int tests = 0;
    int fails = 0;
    int which, cyc;

    localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] D2 = 128'hFEDCBA98765432100123456789ABCDEF;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_BITS(8), .DATA_BITS(128), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .n_rst(n_rst),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_done(rd0_done),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_done(rd1_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .rdata(rdata), .busy(busy),
        .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
        .sram_addr(sram_addr), .sram_data(sram_data)
    );

    function automatic logic [127:0] pat(input logic [7:0] a);
        return {16{a}} ^ {4{32'hC0FFEE11}};
    endfunction

    // SRAM model: preloaded while reset is held, written on write-enable edges.
    assign sram_data = sram_r_en ? mem[sram_addr] : 128'bz;
    always @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
        end else if (sram_w_en) begin
            mem[sram_addr] <= sram_data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Waits up to 20 cycles for a done pulse; which=-1 on timeout, 7 if several at once.
    task automatic wait_done(output int w, output int n);
        w = -1;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rd0_done | rd1_done | wr_done) begin
                n = k;
                if (rd0_done && !rd1_done && !wr_done) w = 0;
                else if (rd1_done && !rd0_done && !wr_done) w = 1;
                else if (wr_done && !rd0_done && !rd1_done) w = 2;
                else w = 7;
                break;
            end
        end
    endtask

    initial begin
        n_rst = 1'b0;
        rd0_req = 0; rd1_req = 0; wr_req = 0;
        rd0_addr = 0; rd1_addr = 0; wr_addr = 0; wr_data = 0;
        tick(); tick();
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ren", 128'(sram_r_en), 128'd0);
        check("rst_wen", 128'(sram_w_en), 128'd0);
        check("rst_addr", 128'(sram_addr), 128'd0);
        check("rst_rdata", rdata, 128'd0);
        check("rst_dones", 128'({rd0_done, rd1_done, wr_done}), 128'd0);
        n_rst = 1'b1;
        tick();

        // 1: single block read
        rd0_req = 1; rd0_addr = 8'h10;
        tick();
        check("t1_ren_c1", 128'(sram_r_en), 128'd1);
        check("t1_addr_c1", 128'(sram_addr), 128'h10);
        check("t1_busy", 128'(busy), 128'd1);
        rd0_addr = 8'h99;
        tick();
        check("t1_ren_c2", 128'(sram_r_en), 128'd1);
        check("t1_addr_c2", 128'(sram_addr), 128'h10);
        tick();
        check("t1_done", 128'(rd0_done), 128'd1);
        check("t1_ren_off", 128'(sram_r_en), 128'd0);
        check("t1_rdata", rdata, pat(8'h10));
        rd0_req = 0;
        tick();
        check("t1_idle_busy", 128'(busy), 128'd0);
        check("t1_done_pulse", 128'(rd0_done), 128'd0);
        check("t1_rdata_hold", rdata, pat(8'h10));

        // 2: write-back
        wr_req = 1; wr_addr = 8'h05; wr_data = D1;
        tick();
        check("t2_wen_c1", 128'(sram_w_en), 128'd1);
        check("t2_addr", 128'(sram_addr), 128'h05);
        check("t2_bus_c1", sram_data, D1);
        wr_data = D2;
        tick();
        check("t2_wen_c2", 128'(sram_w_en), 128'd1);
        check("t2_bus_c2", sram_data, D1);
        tick();
        check("t2_done", 128'(wr_done), 128'd1);
        check("t2_wen_off", 128'(sram_w_en), 128'd0);
        wr_req = 0;
        tick();
        check("t2_mem", mem[5], D1);

        // 3: all three requesters right after reset
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        rd0_req = 1; rd0_addr = 8'h20;
        rd1_req = 1; rd1_addr = 8'h30;
        wr_req = 1; wr_addr = 8'h40; wr_data = D2;
        wait_done(which, cyc);
        check("t3_first_id", 128'(which), 128'd0);
        check("t3_first_lat", 128'(cyc), 128'd3);
        check("t3_rdata0", rdata, pat(8'h20));
        rd0_req = 0;
        wait_done(which, cyc);
        check("t3_second_id", 128'(which), 128'd1);
        check("t3_second_gap", 128'(cyc), 128'd4);
        check("t3_rdata1", rdata, pat(8'h30));
        rd1_req = 0;
        wait_done(which, cyc);
        check("t3_third_id", 128'(which), 128'd2);
        check("t3_third_gap", 128'(cyc), 128'd4);
        wr_req = 0;
        tick();
        check("t3_mem40", mem[8'h40], D2);

        // 4: two readers held continuously alternate
        rd0_req = 1; rd0_addr = 8'h11;
        rd1_req = 1; rd1_addr = 8'h22;
        for (int g = 0; g < 4; g++) begin
            wait_done(which, cyc);
            check($sformatf("t4_id%0d", g), 128'(which), 128'(g % 2));
            check($sformatf("t4_rdata%0d", g), rdata, (g % 2 == 0) ? pat(8'h11) : pat(8'h22));
            if (g > 0) check($sformatf("t4_gap%0d", g), 128'(cyc), 128'd4);
        end
        rd0_req = 0; rd1_req = 0;
        tick();

        // 5: write then key read of the same word
        wr_req = 1; wr_addr = 8'h05; wr_data = D2;
        wait_done(which, cyc);
        check("t5_wr_id", 128'(which), 128'd2);
        wr_req = 0;
        rd1_req = 1; rd1_addr = 8'h05;
        wait_done(which, cyc);
        check("t5_rd_id", 128'(which), 128'd1);
        check("t5_rdata", rdata, D2);
        rd1_req = 0;
        tick();

        // 6: reset pulse during the first READ cycle
        rd0_req = 1; rd0_addr = 8'h33;
        tick();
        check("t6_ren_pre", 128'(sram_r_en), 128'd1);
        n_rst = 1'b0;
        #1;
        check("t6_ren_rst", 128'(sram_r_en), 128'd0);
        check("t6_busy_rst", 128'(busy), 128'd0);
        check("t6_rdata_rst", rdata, 128'd0);
        check("t6_addr_rst", 128'(sram_addr), 128'd0);
        tick();
        check("t6_no_done", 128'({rd0_done, rd1_done, wr_done}), 128'd0);
        n_rst = 1'b1;
        wait_done(which, cyc);
        check("t6_restart_id", 128'(which), 128'd0);
        check("t6_restart_lat", 128'(cyc), 128'd3);
        check("t6_rdata", rdata, pat(8'h33));
        rd0_req = 0;
        tick();
        check("t6_idle", 128'(busy), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
